// File: rtl/result_drain.sv
// result_drain: snapshots a ROWS x COLS array of PE results on start and
// streams the elements out in row-major order over a valid/ready handshake.
// A one-cycle done/acc_clear pulse follows acceptance of the final element.
// A start that arrives while a drain is in progress is ignored, and it sets
// the sticky overrun flag.
module result_drain #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int BITWIDTH = 8,
  parameter int OUTWIDTH = 2 * BITWIDTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [ROWS*COLS*OUTWIDTH-1:0] results,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUTWIDTH-1:0]           out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] out_col,
  output logic                          out_last,
  output logic                          done,
  output logic                          acc_clear,
  output logic                          overrun
);

  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NELEM = ROWS * COLS;
  localparam int BUF_W = NELEM * OUTWIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic              overrun_q, overrun_d;
  logic [BUF_W-1:0]  buf_q;
  logic              capture;
  logic              at_last;
  logic              xfer;
  logic [OUTWIDTH-1:0] sel_data;

  // The final element sits at the bottom-right corner of the array.
  assign at_last = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
  assign xfer    = (state_q == S_STREAM) && out_ready;

  // Next-state logic: walk the array row-major; track start requests that
  // arrive while busy.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_STREAM;
          row_d     = '0;
          col_d     = '0;
          overrun_d = 1'b0;
          capture   = 1'b1;
        end
      end
      S_STREAM: begin
        if (start) begin
          overrun_d = 1'b1;
        end
        if (xfer) begin
          if (at_last) begin
            state_d = S_DONE;
          end else if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        // The done pulse lasts one cycle; any start seen here is still an
        // overrun because the drain has not returned to idle yet.
        if (start) begin
          overrun_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers: FSM state, element position and the sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      overrun_q <= overrun_d;
    end
  end

  // Snapshot buffer: loaded only on an accepted start, so later changes on
  // results never reach the stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q <= '0;
    end else if (capture) begin
      buf_q <= results;
    end
  end

  // Element select: a plain compare-based mux keeps the index arithmetic in
  // integer width and avoids a variable part-select.
  always_comb begin
    int idx;
    sel_data = '0;
    idx      = int'(row_q) * COLS + int'(col_q);
    for (int i = 0; i < NELEM; i++) begin
      if (idx == i) begin
        sel_data = buf_q[i*OUTWIDTH +: OUTWIDTH];
      end
    end
  end

  // Output decode: the data, position and last outputs are forced to zero
  // whenever no element is presented.
  always_comb begin
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_STREAM);
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    out_last  = 1'b0;
    done      = (state_q == S_DONE);
    acc_clear = (state_q == S_DONE);
    overrun   = overrun_q;
    if (state_q == S_STREAM) begin
      out_data = sel_data;
      out_row  = row_q;
      out_col  = col_q;
      out_last = at_last;
    end
  end

endmodule
